// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with valid/last framing
module piso_serializer #(
  parameter int BUS_WIDTH = 8,
  parameter bit LSB_FIRST = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] in,
  input  logic                 load,
  output logic                 ready,
  output logic                 out,
  output logic                 out_valid,
  output logic                 last
);
`ifdef SERIALIZER_PARITY_EN
  localparam int LAST_IDX = BUS_WIDTH;
`else
  localparam int LAST_IDX = BUS_WIDTH - 1;
`endif
  localparam int CW = LAST_IDX > 0 ? $clog2(LAST_IDX + 1) : 1;
  localparam logic [CW-1:0] END_CNT = CW'(LAST_IDX);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [BUS_WIDTH-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic take, data_bit;
  assign out_valid = state == SHIFT;
  assign last = out_valid && cnt == END_CNT;
  assign ready = state == IDLE || last;
  assign take = ready && load;
  assign data_bit = LSB_FIRST ? sr[0] : sr[BUS_WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
  logic par, par_n;
  assign out = out_valid && (last ? par : data_bit);
  assign par_n = take ? ^in : par;
  always_ff @(posedge clock)
    par <= reset ? 1'b0 : par_n;
`else
  assign out = out_valid && data_bit;
`endif
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    if (take) begin
      state_n = SHIFT;
      sr_n = in;
      cnt_n = '0;
    end else if (last) begin
      state_n = IDLE;
    end else if (out_valid) begin
      cnt_n = cnt + CW'(1);
      sr_n = LSB_FIRST ? sr >> 1 : sr << 1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out shift engine. It is the read-out end of a loaded register: it accepts a BUS_WIDTH word on a load pulse and presents it one bit per clock on a valid-qualified serial output. It sits between the CPU datapath's parallel registers and any bit-serial consumer, such as a debug/UART-style link or a serial bus master.

Parameters:
- BUS_WIDTH, 8, width of the parallel word; legal values are 1 and above.
- LSB_FIRST, 1, bit order: 1 sends bit 0 first; 0 sends bit BUS_WIDTH-1 first.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in  input  BUS_WIDTH  parallel word to serialize.
- load  input  1  request to capture `in`; accepted only when `ready`=1 at the rising edge.
- ready  output  1  high when a load will be accepted this cycle.
- out  output  1  current serial bit; forced to 0 when `out_valid`=0.
- out_valid  output  1  `out` carries a valid bit this cycle.
- last  output  1  high with `out_valid` on the final bit of a word.

Behaviour:
- Reset (synchronous, active-high, priority over `load`):
  - state=IDLE, shift register=0, bit counter=0.
  - ready=1, out=0, out_valid=0, last=0.
  - Reset asserted mid-word aborts the word. The cycle after the reset edge shows the reset values; remaining bits are discarded.
- States: IDLE, SHIFT.
- IDLE:
  - ready=1, out_valid=0.
  - load=1 at a rising edge: capture `in`, counter=0, go to SHIFT.
  - load=0: stay in IDLE; `in` is ignored.
- SHIFT:
  - out_valid=1. `out` = next bit per LSB_FIRST.
  - The counter increments each edge.
  - last=1 when counter==BUS_WIDTH-1.
- Latency: load accepted at edge N, so the first bit is visible in the cycle after edge N. A word occupies exactly BUS_WIDTH consecutive valid cycles.
- ready = (state==IDLE) || last. `load` while ready=0 is ignored and has no side effects.
- Back-to-back: load=1 during the `last` cycle captures the new word at that edge. Its first bit follows with no gap cycle.
- End of word: on the `last` edge with no load, go to IDLE; out_valid=0 in the next cycle.
- BUS_WIDTH=1: every word is a single cycle with out_valid=1 and last=1. ready stays 1 throughout.
- Counter width is max(1, clog2(BUS_WIDTH)). The counter never wraps past BUS_WIDTH-1.
- All outputs are registered or decoded from registered state. There is no combinational path from `in` to `out`.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - One extra SHIFT cycle follows the data bits. In it, `out` = even parity (XOR of the captured word) and out_valid=1.
  - `last` moves from the final data bit to the parity cycle.
  - A word occupies BUS_WIDTH+1 cycles. ready = IDLE || (parity cycle).
- Undefined: no parity cycle; behaviour is exactly as above.

Test Plan:
- Reset then idle: hold reset 2 cycles, release with load=0 -> ready=1, out_valid=0, out=0, last=0 indefinitely.
- BUS_WIDTH=8, LSB_FIRST=1, load 8'hA5 at edge 0:
  - Cycles 1..8 give out = 1,0,1,0,0,1,0,1 with out_valid=1.
  - last=1 only in cycle 8; ready=0 in cycles 1..7 and 1 in cycle 8.
  - Cycle 9 has out_valid=0.
- Back-to-back: load 8'hA5, then load 8'h3C in A5's `last` cycle -> 16 contiguous valid cycles. The second 8 bits are 0,0,1,1,1,1,0,0; last pulses in cycles 8 and 16.
- Ignored load plus LSB_FIRST=0:
  - Load 8'h80, then pulse load with 8'hFF in cycle 3.
  - Output is 1,0,0,0,0,0,0,0 and the 8'hFF is never sent.
- Reset mid-word: load 8'hFF, assert reset during cycle 3 -> cycle 4 has out_valid=0, ready=1, out=0. A following load of 8'h01 serializes normally.
- SERIALIZER_PARITY_EN defined, load 8'h07 -> 8 data bits 1,1,1,0,0,0,0,0, then cycle 9 out=1 (parity), last=1 only in cycle 9, ready=1 in cycle 9.
